// File: rtl/mem_ctrl_if.sv
// Request/response and byte-wide RAM bus bundle for mem_ctrl.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              ifetch_en;
  logic [ADDR_W-1:0] ifetch_addr;
  logic              ifetch_ok;
  logic [31:0]       ifetch_ins;
  logic              lsb_en;
  logic              lsb_wr;
  logic [1:0]        lsb_len;
  logic [ADDR_W-1:0] lsb_addr;
  logic [31:0]       lsb_wdata;
  logic              lsb_ok;
  logic [31:0]       lsb_rdata;
  logic              flush;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport slave (
    input  ifetch_en, ifetch_addr, lsb_en, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
           flush, mem_din, io_buffer_full,
    output ifetch_ok, ifetch_ins, lsb_ok, lsb_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output ifetch_en, ifetch_addr, lsb_en, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
           flush, mem_din, io_buffer_full,
    input  ifetch_ok, ifetch_ins, lsb_ok, lsb_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Serves 32-bit fetch and load/store requests as sequential byte accesses
// on a synchronous-read RAM bus; LSB has priority, flush aborts reads.
module mem_ctrl #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] IO_ADDR_BASE = ADDR_W'('h30000)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  mem_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              is_fetch_q, is_fetch_d;
  logic              wr_q, wr_d;
  logic              io_q, io_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;

  logic [2:0]        wr_cnt;
  logic [1:0]        rd_idx;
  logic              io_stall;
  logic              reading;
  logic [ADDR_W-1:0] replay_a;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign rd_idx   = cnt_q[1:0] - 2'd1;
  assign io_stall = io_q && bus.io_buffer_full;
  assign reading  = (state_q == IF_RD) || (state_q == LS_RD);
  assign replay_a = addr_q + ADDR_W'(cnt_q) - ADDR_W'(1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    nbytes_d   = nbytes_q;
    cnt_d      = cnt_q;
    is_fetch_d = is_fetch_q;
    wr_d       = wr_q;
    io_d       = io_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    wr_cnt     = cnt_q;
    if (rdy) begin
      unique case (state_q)
        IDLE: begin
          if (!bus.flush && (bus.lsb_en || bus.ifetch_en)) begin
            cnt_d    = '0;
            data_d   = '0;
            mem_wr_d = 1'b0;
            if (bus.lsb_en) begin
              addr_d     = bus.lsb_addr;
              wdata_d    = bus.lsb_wdata;
              wr_d       = bus.lsb_wr;
              is_fetch_d = 1'b0;
              io_d       = bus.lsb_addr >= IO_ADDR_BASE;
              nbytes_d   = len_bytes(bus.lsb_len);
              state_d    = bus.lsb_wr ? LS_WR : LS_RD;
            end else begin
              addr_d     = bus.ifetch_addr;
              wr_d       = 1'b0;
              is_fetch_d = 1'b1;
              io_d       = 1'b0;
              nbytes_d   = 3'd4;
              state_d    = IF_RD;
            end
            mem_a_d = addr_d;
          end
        end
        IF_RD, LS_RD: begin
          if (bus.flush) begin
            state_d = IDLE;
          end else begin
            // byte cnt-1 was issued last cycle and is on mem_din now
            if (cnt_q != '0) data_d[{rd_idx, 3'b000} +: 8] = bus.mem_din;
            if (cnt_q == nbytes_q) begin
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + 3'd1;
              if (cnt_d < nbytes_q) mem_a_d = addr_q + ADDR_W'(cnt_d);
            end
          end
        end
        LS_WR: begin
          if (mem_wr_q && !io_stall) wr_cnt = cnt_q + 3'd1;
          cnt_d = wr_cnt;
          if (wr_cnt == nbytes_q) begin
            mem_wr_d = 1'b0;
            state_d  = DONE;
          end else begin
            mem_wr_d   = 1'b1;
            mem_a_d    = addr_q + ADDR_W'(wr_cnt);
            mem_dout_d = wdata_q[{wr_cnt[1:0], 3'b000} +: 8];
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      nbytes_q   <= '0;
      cnt_q      <= '0;
      is_fetch_q <= 1'b0;
      wr_q       <= 1'b0;
      io_q       <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      nbytes_q   <= nbytes_d;
      cnt_q      <= cnt_d;
      is_fetch_q <= is_fetch_d;
      wr_q       <= wr_d;
      io_q       <= io_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  // While frozen mid-read, re-present the address of the byte still to be
  // captured so the RAM output is valid again on the first cycle after rdy.
  assign bus.mem_a     = (!rdy && reading && cnt_q != '0) ? replay_a : mem_a_q;
  assign bus.mem_dout  = mem_dout_q;
  assign bus.mem_wr    = mem_wr_q && rdy && !io_stall;
  assign bus.ifetch_ins = data_q;
  assign bus.lsb_rdata  = data_q;
  assign bus.ifetch_ok  = rdy && (state_q == DONE) && is_fetch_q && !bus.flush;
  assign bus.lsb_ok     = rdy && (state_q == DONE) && !is_fetch_q && (wr_q || !bus.flush);
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, scoreboarded writes and ok responses,
// table-driven LSB requests plus hand-written fetch/flush/reset sequences.
module tb_mem_ctrl;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;

  mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_ctrl #(.ADDR_W(ADDR_W), .IO_ADDR_BASE(32'h30000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // 4 KiB RAM aliased on the low address bits; IO addresses are not stored
  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    if (!rst_n) begin
      ram[12'h000] <= 8'h13; ram[12'h001] <= 8'h05; ram[12'h002] <= 8'hA0; ram[12'h003] <= 8'h00;
      ram[12'h040] <= 8'h78; ram[12'h041] <= 8'h56; ram[12'h042] <= 8'h34; ram[12'h043] <= 8'h12;
      ram[12'h100] <= 8'h11; ram[12'h101] <= 8'h22; ram[12'h102] <= 8'h33; ram[12'h103] <= 8'h44;
      ram[12'hFFE] <= 8'hAA; ram[12'hFFF] <= 8'hBB;
    end else if (bus.mem_wr && !(bus.mem_a >= 32'h30000 && bus.mem_a < 32'hFFFF0000)) begin
      ram[bus.mem_a[11:0]] <= bus.mem_dout;
    end
    bus.mem_din <= ram[bus.mem_a[11:0]];
  end

  typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;
  typedef struct packed { logic is_load; logic [31:0] d; } lsb_t;
  typedef struct {
    bit wr; logic [1:0] len; logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] exp; int lat; int kind; int at; int endc;
  } vec_t;

  wr_t         wr_exp[$];
  lsb_t        lsb_exp[$];
  logic [31:0] fetch_exp[$];
  int checks = 0;
  int errors = 0;
  int fetch_ok_cnt = 0;
  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t  w;
    lsb_t l;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.mem_wr) begin
          if (wr_exp.size() == 0) check("unexpected_write", {32'h0, bus.mem_a}, 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            w = wr_exp.pop_front();
            check("wr_addr", bus.mem_a, w.a);
            check("wr_data", bus.mem_dout, w.d);
          end
        end
        if (bus.ifetch_ok) begin
          fetch_ok_cnt++;
          if (fetch_exp.size() == 0) check("unexpected_ifetch_ok", bus.ifetch_ins, 64'hFFFF_FFFF_FFFF_FFFF);
          else check("ifetch_ins", bus.ifetch_ins, fetch_exp.pop_front());
        end
        if (bus.lsb_ok) begin
          if (lsb_exp.size() == 0) check("unexpected_lsb_ok", bus.lsb_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            l = lsb_exp.pop_front();
            if (l.is_load) check("lsb_rdata", bus.lsb_rdata, l.d);
          end
        end
      end
    end
  endtask

  // kind: 1 = rdy low, 2 = io_buffer_full high, 3 = flush high
  task automatic set_stall(input int kind, input bit v);
    case (kind)
      1: rdy = !v;
      2: bus.io_buffer_full = v;
      3: bus.flush = v;
      default: ;
    endcase
  endtask

  task automatic stall_hook(input vec_t v, input int lat);
    if (lat == v.at) set_stall(v.kind, 1'b1);
    if (lat == v.endc) set_stall(v.kind, 1'b0);
  endtask

  task automatic lsb_req(input vec_t v);
    int n;
    int lat;
    bit seen;
    n = (v.len == 2'd0) ? 1 : (v.len == 2'd1) ? 2 : 4;
    if (v.wr)
      for (int k = 0; k < n; k++) wr_exp.push_back('{a: v.addr + k, d: v.wdata[8*k +: 8]});
    lsb_exp.push_back('{is_load: !v.wr, d: v.exp});
    bus.lsb_en = 1'b1; bus.lsb_wr = v.wr; bus.lsb_len = v.len;
    bus.lsb_addr = v.addr; bus.lsb_wdata = v.wdata;
    @(posedge clk); #1;
    lat = 0; seen = 1'b0;
    stall_hook(v, lat);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      stall_hook(v, lat);
      if (bus.lsb_ok) seen = 1'b1;
    end
    bus.lsb_en = 1'b0;
    check("lsb_latency", lat, v.lat);
    @(posedge clk); #1;
    rdy = 1'b1; bus.io_buffer_full = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic fetch_req(input logic [31:0] addr, input logic [31:0] ins);
    int lat;
    bit seen;
    fetch_exp.push_back(ins);
    bus.ifetch_en = 1'b1; bus.ifetch_addr = addr;
    @(posedge clk); #1;
    lat = 0; seen = 1'b0;
    check("fetch_mem_a", bus.mem_a, addr);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat < 4) check("fetch_mem_a", bus.mem_a, addr + lat);
      if (bus.ifetch_ok) seen = 1'b1;
    end
    bus.ifetch_en = 1'b0;
    check("fetch_latency", lat, 5);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, lsb_lat, f_lat, ok_before;
    rst_n = 1'b0; rdy = 1'b1;
    bus.ifetch_en = 1'b0; bus.ifetch_addr = '0;
    bus.lsb_en = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_len = '0; bus.lsb_addr = '0; bus.lsb_wdata = '0;
    bus.flush = 1'b0; bus.io_buffer_full = 1'b0;

    vecs[0]  = '{1'b1, 2'd1, 32'h200,      32'hBEEF,     32'h0,        3, 0, 0, 0};
    vecs[1]  = '{1'b0, 2'd0, 32'h201,      32'h0,        32'h000000BE, 2, 0, 0, 0};
    vecs[2]  = '{1'b0, 2'd2, 32'h100,      32'h0,        32'h44332211, 5, 0, 0, 0};
    vecs[3]  = '{1'b0, 2'd1, 32'h102,      32'h0,        32'h00004433, 3, 0, 0, 0};
    vecs[4]  = '{1'b0, 2'd3, 32'hFFFFFFFE, 32'h0,        32'h0513BBAA, 5, 0, 0, 0};
    vecs[5]  = '{1'b1, 2'd0, 32'h30000,    32'h41,       32'h0,        5, 2, 1, 4};
    vecs[6]  = '{1'b1, 2'd2, 32'h300,      32'hCAFEF00D, 32'h0,        5, 3, 2, 99};
    vecs[7]  = '{1'b0, 2'd2, 32'h300,      32'h0,        32'hCAFEF00D, 5, 0, 0, 0};
    vecs[8]  = '{1'b0, 2'd2, 32'h100,      32'h0,        32'h44332211, 8, 1, 2, 5};
    vecs[9]  = '{1'b1, 2'd2, 32'hFFFFFFFF, 32'h12345678, 32'h0,        5, 0, 0, 0};
    vecs[10] = '{1'b0, 2'd2, 32'h0,        32'h0,        32'h00123456, 5, 0, 0, 0};

    fork monitor(); join_none

    #12;
    check("rst_mem_a", bus.mem_a, 0);
    check("rst_mem_wr", bus.mem_wr, 0);
    check("rst_mem_dout", bus.mem_dout, 0);
    check("rst_oks", {bus.ifetch_ok, bus.lsb_ok}, 0);
    check("rst_data", {bus.ifetch_ins, bus.lsb_rdata}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    fetch_req(32'h0, 32'h00A00513);

    // simultaneous fetch and load: load first, fetch accepted after DONE
    fetch_exp.push_back(32'h00A00513);
    lsb_exp.push_back('{is_load: 1'b1, d: 32'h44332211});
    bus.ifetch_en = 1'b1; bus.ifetch_addr = 32'h0;
    bus.lsb_en = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_len = 2'd2; bus.lsb_addr = 32'h100;
    @(posedge clk); #1;
    lat = 0; lsb_lat = -1; f_lat = -1;
    for (int i = 0; i < 40 && f_lat < 0; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.lsb_ok && lsb_lat < 0) begin lsb_lat = lat; bus.lsb_en = 1'b0; end
      if (bus.ifetch_ok) begin f_lat = lat; bus.ifetch_en = 1'b0; end
    end
    bus.lsb_en = 1'b0; bus.ifetch_en = 1'b0;
    check("arb_lsb_latency", lsb_lat, 5);
    check("arb_fetch_latency", f_lat, 12);
    @(posedge clk); #1;

    // flush after two fetch bytes captured
    ok_before = fetch_ok_cnt;
    bus.ifetch_en = 1'b1; bus.ifetch_addr = 32'h100;
    repeat (4) begin @(posedge clk); #1; end
    bus.flush = 1'b1; bus.ifetch_en = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_no_ifetch_ok", fetch_ok_cnt, ok_before);
    fetch_req(32'h40, 32'h12345678);

    // asynchronous reset mid-fetch
    bus.ifetch_en = 1'b1; bus.ifetch_addr = 32'h40;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_reset_mem_a", bus.mem_a, 32'h42);
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_a", bus.mem_a, 0);
    check("async_rst_ins", bus.ifetch_ins, 0);
    check("async_rst_ok", bus.ifetch_ok, 0);
    bus.ifetch_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) lsb_req(vecs[i]);

    repeat (3) begin @(posedge clk); #1; end
    check("wr_queue_drained", wr_exp.size(), 0);
    check("lsb_queue_drained", lsb_exp.size(), 0);
    check("fetch_queue_drained", fetch_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
